// File: rtl/uart_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_pkg : shared UART line-state encoding and framing constants
// Rev 1.0
// ------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int FRAME_BITS           = 10;
  localparam int DEFAULT_CLKS_PER_BIT = 234;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_tx_fifo_if : CPU-side send handshake, status flags and tx line
// Rev 1.0
// ------------------------------------------------------------------
interface uart_tx_fifo_if;

  logic       wr;
  logic [7:0] din;
  logic       ack;
  logic       full;
  logic       empty;
  logic       busy;
  logic       overflow;
  logic       tx;

  modport master (
    output wr, din,
    input  ack, full, empty, busy, overflow, tx
  );

  modport slave (
    input  wr, din,
    output ack, full, empty, busy, overflow, tx
  );

endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// sync_fifo : single-clock FIFO, flags decoded from registered count
// Rev 1.0
// ------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             push_i,
  input  wire logic [WIDTH-1:0] din_i,
  input  wire logic             pop_i,
  output logic      [WIDTH-1:0] dout_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int               ADDR_W   = $clog2(DEPTH);
  localparam logic [ADDR_W:0]  FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wptr_q;
  logic [ADDR_W-1:0] rptr_q;
  logic [ADDR_W:0]   count_q;
  logic              do_push;
  logic              do_pop;

  // A push into a full FIFO is refused even when a pop lands in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i  && !empty_o;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign dout_o  = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_tx_fifo : buffered 8N1 UART transmitter fed by a byte queue
// Rev 1.0
// ------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16
) (
  input  wire logic     clk,
  input  wire logic     rst,
  uart_tx_fifo_if.slave bus
);

  localparam int               BC_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BC_W-1:0]  BC_LAST = BC_W'(CLKS_PER_BIT - 1);

  uart_state_e state_q, state_d;
  logic [BC_W-1:0] bc_q, bc_d;
  logic [2:0]      bi_q, bi_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            ack_q, ack_d;
  logic            ovf_q, ovf_d;
  logic            wr_q;

  logic       push;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_dout;

  assign push = bus.wr && !wr_q;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (bus.din),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bc_q    <= '0;
      bi_q    <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bc_q    <= bc_d;
      bi_q    <= bi_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ack_q   <= ack_d;
      ovf_q   <= ovf_d;
      wr_q    <= bus.wr;
    end
  end

  always_comb begin
    ack_d = ack_q;
    if (push && !fifo_full) begin
      ack_d = 1'b1;
    end else if (!bus.wr) begin
      ack_d = 1'b0;
    end
    ovf_d = ovf_q | (push & fifo_full);
  end

  always_comb begin
    state_d = state_q;
    bc_d    = bc_q;
    bi_d    = bi_q;
    shift_d = shift_q;
    pop     = 1'b0;
    tx_d    = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          bc_d    = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bc_q == BC_LAST) begin
          bc_d    = '0;
          bi_d    = '0;
          state_d = ST_DATA;
        end else begin
          bc_d = bc_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (bc_q == BC_LAST) begin
          bc_d    = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bi_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bi_d = bi_q + 3'd1;
          end
        end else begin
          bc_d = bc_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (bc_q == BC_LAST) begin
          bc_d = '0;
          // Chain straight into the next start bit when more bytes wait.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          bc_d = bc_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The line level is computed from the next state so tx can be a flop.
    unique case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  assign bus.ack      = ack_q;
  assign bus.full     = fifo_full;
  assign bus.empty    = fifo_empty;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.overflow = ovf_q;
  assign bus.tx       = tx_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_uart_tx_fifo : directed self-checking bench for uart_tx_fifo
// Rev 1.0
// ------------------------------------------------------------------
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = FRAME_BITS * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_fifo_if bus();

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Checks every sample of one frame, starting on its first start-bit sample.
  task automatic check_frame(input string tag, input logic [7:0] b);
    for (int i = 0; i < FRAME; i++) begin
      int   k;
      logic e;
      k = i / CPB;
      if (k == 0)                   e = 1'b0;
      else if (k == FRAME_BITS - 1) e = 1'b1;
      else                          e = b[k-1];
      check_eq(tag, 32'(bus.tx), 32'(e));
      @(negedge clk);
    end
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (bus.tx !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, " start"}, 32'(bus.tx), 32'd0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    bus.din = b;
    bus.wr  = 1'b1;
    @(negedge clk);
    bus.wr  = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle_quiet(input string tag, input int cycles);
    int lows = 0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.tx !== 1'b1) lows++;
      @(negedge clk);
    end
    check_eq(tag, 32'(lows), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.wr  = 1'b0;
    bus.din = 8'h00;
    rst     = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst tx",       32'(bus.tx),       32'd1);
    check_eq("rst ack",      32'(bus.ack),      32'd0);
    check_eq("rst full",     32'(bus.full),     32'd0);
    check_eq("rst empty",    32'(bus.empty),    32'd1);
    check_eq("rst busy",     32'(bus.busy),     32'd0);
    check_eq("rst overflow", 32'(bus.overflow), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single byte: ack one cycle after the push, start bit one cycle later.
    bus.din = 8'hA5;
    bus.wr  = 1'b1;
    @(negedge clk);
    check_eq("t1 ack",   32'(bus.ack),   32'd1);
    check_eq("t1 tx",    32'(bus.tx),    32'd1);
    check_eq("t1 busy",  32'(bus.busy),  32'd0);
    check_eq("t1 empty", 32'(bus.empty), 32'd0);
    bus.wr = 1'b0;
    @(negedge clk);
    check_eq("t1 busy start", 32'(bus.busy),  32'd1);
    check_eq("t1 empty pop",  32'(bus.empty), 32'd1);
    check_eq("t1 ack low",    32'(bus.ack),   32'd0);
    check_frame("t1 frame", 8'hA5);
    check_eq("t1 busy end", 32'(bus.busy), 32'd0);
    check_eq("t1 tx end",   32'(bus.tx),   32'd1);

    // Back-to-back frames with no idle gap.
    fork
      begin
        push_byte(8'h01);
        push_byte(8'h80);
        push_byte(8'hFF);
      end
      begin
        wait_start("t2");
        check_frame("t2 f0", 8'h01);
        check_frame("t2 f1", 8'h80);
        check_frame("t2 f2", 8'hFF);
      end
    join
    check_eq("t2 empty", 32'(bus.empty), 32'd1);
    check_eq("t2 busy",  32'(bus.busy),  32'd0);

    // Overflow: one in flight, four queued, sixth dropped.
    fork
      begin
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        push_byte(8'h55);
        check_eq("t3 full",    32'(bus.full),     32'd1);
        check_eq("t3 ovf pre", 32'(bus.overflow), 32'd0);
        bus.din = 8'h66;
        bus.wr  = 1'b1;
        @(negedge clk);
        check_eq("t3 ack drop", 32'(bus.ack),      32'd0);
        check_eq("t3 ovf set",  32'(bus.overflow), 32'd1);
        bus.wr = 1'b0;
        @(negedge clk);
      end
      begin
        wait_start("t3");
        check_frame("t3 f11", 8'h11);
        check_frame("t3 f22", 8'h22);
        check_frame("t3 f33", 8'h33);
        check_frame("t3 f44", 8'h44);
        check_frame("t3 f55", 8'h55);
      end
    join
    idle_quiet("t3 no sixth frame", 60);
    check_eq("t3 empty", 32'(bus.empty), 32'd1);

    // wr held high: one push only, ack follows wr low by one cycle.
    bus.din = 8'h5A;
    bus.wr  = 1'b1;
    fork
      begin
        repeat (100) @(negedge clk);
        check_eq("t4 ack held", 32'(bus.ack), 32'd1);
        bus.wr = 1'b0;
        @(negedge clk);
        check_eq("t4 ack drop", 32'(bus.ack), 32'd0);
      end
      begin
        wait_start("t4");
        check_frame("t4 frame", 8'h5A);
        idle_quiet("t4 single frame", 60);
      end
    join

    // Reset mid-DATA with a second byte still queued.
    check_eq("t5 ovf sticky", 32'(bus.overflow), 32'd1);
    push_byte(8'h3C);
    check_eq("t5 start", 32'(bus.tx), 32'd0);
    push_byte(8'h77);
    repeat (8) @(negedge clk);
    check_eq("t5 busy data", 32'(bus.busy),  32'd1);
    check_eq("t5 queued",    32'(bus.empty), 32'd0);
    check_eq("t5 tx data",   32'(bus.tx),    32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t5 tx",    32'(bus.tx),       32'd1);
    check_eq("t5 busy",  32'(bus.busy),     32'd0);
    check_eq("t5 empty", 32'(bus.empty),    32'd1);
    check_eq("t5 ovf",   32'(bus.overflow), 32'd0);
    check_eq("t5 ack",   32'(bus.ack),      32'd0);
    rst = 1'b0;
    idle_quiet("t5 no frame", 100);

    // Ten bytes through a depth-4 queue: pointers wrap twice.
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          int n = 0;
          while (bus.full && n < 200) begin
            @(negedge clk);
            n++;
          end
          push_byte(8'(i));
        end
      end
      begin
        for (int j = 0; j < 10; j++) begin
          wait_start("t6");
          check_frame("t6 frame", 8'(j));
        end
      end
    join
    check_eq("t6 empty", 32'(bus.empty),    32'd1);
    check_eq("t6 ovf",   32'(bus.overflow), 32'd0);
    check_eq("t6 busy",  32'(bus.busy),     32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
